rv32i_fetch_queue: RTL and testbench

- Parametrised instruction-fetch front end for the next-generation RV32I core. Replaces the direct next_pc-to-ROM fetch path.
- Issues word fetches to an instruction memory over a valid/ready request channel with in-order, variable-latency responses.
- Buffers fetched instructions in a prefetch queue and presents them with their PC to decode over a valid/ready handshake.
- Handles control-flow redirects by flushing buffered and in-flight fetches.

---
 rtl/rv32i_fetch_queue.sv | 166 ++++++++++++++++
 tb/tb_rv32i_fetch_queue.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_fetch_queue.sv
// rtl/rv32i_fetch_queue.sv - RV32I instruction-fetch front end with prefetch queue
//
// Purpose:
//   Issues word-aligned fetches to instruction memory, buffers returned words
//   with their PCs in a small prefetch queue and hands them to decode. A
//   redirect flushes the queue and marks every in-flight fetch as stale so
//   its response is discarded when it eventually returns.
//
// Ports:
//   clk             in   rising-edge clock
//   reset_n         in   asynchronous active-low reset
//   imem_req_valid  out  fetch request valid
//   imem_req_ready  in   memory accepts the request this cycle
//   imem_req_addr   out  word-aligned fetch address
//   imem_rsp_valid  in   response valid (in request order)
//   imem_rsp_data   in   fetched instruction word
//   redirect_valid  in   control-flow change, highest priority
//   redirect_pc     in   redirect target (low two bits ignored)
//   inst_valid      out  queue head valid
//   inst_ready      in   decode consumes the head
//   inst_data       out  head instruction
//   inst_pc         out  PC of the head instruction

module rv32i_fetch_queue #(
  parameter int unsigned     XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC    = 32'h8000_0000,
  parameter int unsigned     QUEUE_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst_data,
  output logic [XLEN-1:0] inst_pc
);

  localparam int unsigned AW = $clog2(QUEUE_DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned CW = $clog2(QUEUE_DEPTH + 1);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(QUEUE_DEPTH);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;

  logic [31:0]     data_mem [QUEUE_DEPTH];
  logic [XLEN-1:0] pc_mem   [QUEUE_DEPTH];

  logic [PW-1:0]   occupancy;
  logic [CW:0]     credit_used;
  logic [AW-1:0]   rd_idx;
  logic [AW-1:0]   wr_idx;
  logic            empty;
  logic            req_fire;
  logic            rsp_fire;
  logic            push;
  logic            pop;
  logic [XLEN-1:0] redirect_aligned;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign occupancy   = wr_ptr_q - rd_ptr_q;
  assign empty       = (wr_ptr_q == rd_ptr_q);
  assign rd_idx      = rd_ptr_q[AW-1:0];
  assign wr_idx      = wr_ptr_q[AW-1:0];

  // Every in-flight request (stale or not) reserves a queue slot, so a
  // returning response can never find the queue full.
  assign credit_used = {1'b0, outstanding_q} + (CW + 1)'(occupancy);

  // reset_n gating keeps the request channel quiet while reset is held,
  // since the registered state alone would otherwise advertise full credit.
  assign imem_req_valid = reset_n && !redirect_valid && (credit_used < DEPTH_W);
  assign imem_req_addr  = fetch_pc_q;

  assign req_fire = imem_req_valid && imem_req_ready;
  // Responses with nothing outstanding are spurious and ignored entirely.
  assign rsp_fire = imem_rsp_valid && (outstanding_q != '0);
  assign push     = rsp_fire && !redirect_valid && (drop_cnt_q == '0);
  assign pop      = !empty && inst_ready;

  assign redirect_aligned = {redirect_pc[XLEN-1:2], 2'b00};

  assign inst_valid = !empty;
  assign inst_data  = empty ? '0 : data_mem[rd_idx];
  assign inst_pc    = empty ? '0 : pc_mem[rd_idx];

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    drop_cnt_d    = drop_cnt_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    outstanding_d = outstanding_q + CW'(req_fire) - CW'(rsp_fire);

    if (redirect_valid) begin
      fetch_pc_d = redirect_aligned;
      rsp_pc_d   = redirect_aligned;
      // Flush: nothing is pushed this cycle, so catching the read pointer up
      // to the write pointer empties the queue (a concurrent pop is subsumed).
      rd_ptr_d   = wr_ptr_q;
      // Every request still in flight after this cycle is now stale.
      drop_cnt_d = outstanding_q - CW'(rsp_fire);
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + XLEN'(4);
      end
      if (rsp_fire) begin
        if (drop_cnt_q != '0) begin
          drop_cnt_d = drop_cnt_q - CW'(1);
        end else begin
          wr_ptr_d = wr_ptr_q + PW'(1);
          rsp_pc_d = rsp_pc_q + XLEN'(4);
        end
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end

  // Storage needs no reset: outputs are masked whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_idx] <= imem_rsp_data;
      pc_mem[wr_idx]   <= rsp_pc_q;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    push |-> (occupancy < PW'(QUEUE_DEPTH)));

  a_drop_bounded: assert property (@(posedge clk) disable iff (!reset_n)
    drop_cnt_q <= outstanding_q);

  a_credit_bounded: assert property (@(posedge clk) disable iff (!reset_n)
    credit_used <= DEPTH_W);

endmodule

// File: tb/tb_rv32i_fetch_queue.sv
// tb/tb_rv32i_fetch_queue.sv - randomized self-checking bench for rv32i_fetch_queue

module tb_rv32i_fetch_queue;

  localparam int          XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam int          DEPTH    = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;

  always #5 clk = ~clk;

  rv32i_fetch_queue #(
    .XLEN        (XLEN),
    .RESET_PC    (RESET_PC),
    .QUEUE_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc)
  );

  // Memory + reference model: each accepted request is a record carrying its
  // address, the cycle its response is due and whether a redirect made it stale.
  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } flight_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } inst_t;

  flight_t     inflight[$];
  inst_t       exp_q[$];
  logic [31:0] m_fetch_pc;
  int          cyc;
  int          last_due;
  int          n_checks;
  int          n_pass;
  int          lat_min, lat_max;
  int          p_ready, p_inst, p_redir;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic model_reset();
    inflight.delete();
    exp_q.delete();
    m_fetch_pc = RESET_PC;
    last_due   = cyc;
  endtask

  task automatic step();
    bit      redir;
    bit      rsp;
    bit      exp_req;
    bit      do_pop;
    int      lat;
    int      due;
    flight_t f;
    inst_t   e;

    @(negedge clk);
    cyc++;
    redir          = ($urandom_range(99) < p_redir);
    redirect_valid = redir;
    redirect_pc    = 32'h8000_0000 | 32'($urandom_range(0, 16'hffff));
    imem_req_ready = ($urandom_range(99) < p_ready);
    inst_ready     = ($urandom_range(99) < p_inst);
    rsp            = (inflight.size() > 0) && (inflight[0].due <= cyc);
    if (rsp) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(inflight[0].addr);
    end else begin
      // Occasional spurious response while nothing is outstanding.
      imem_rsp_valid = (inflight.size() == 0) && ($urandom_range(99) < 5);
      imem_rsp_data  = $urandom;
    end
    #1;

    exp_req = !redir && ((inflight.size() + exp_q.size()) < DEPTH);
    check_eq("req_valid", 32'(imem_req_valid), 32'(exp_req));
    if (exp_req) check_eq("req_addr", imem_req_addr, m_fetch_pc);
    check_eq("inst_valid", 32'(inst_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      check_eq("inst_pc", inst_pc, exp_q[0].pc);
      check_eq("inst_data", inst_data, exp_q[0].data);
    end

    do_pop = inst_ready && (exp_q.size() != 0);
    if (do_pop) void'(exp_q.pop_front());
    if (rsp) begin
      f = inflight.pop_front();
      if (!f.stale && !redir) begin
        e.pc   = f.addr;
        e.data = mem_word(f.addr);
        exp_q.push_back(e);
      end
    end
    if (redir) begin
      foreach (inflight[i]) inflight[i].stale = 1'b1;
      exp_q.delete();
      m_fetch_pc = {redirect_pc[31:2], 2'b00};
    end else if (exp_req && imem_req_ready) begin
      lat = $urandom_range(lat_max, lat_min);
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      f.addr  = m_fetch_pc;
      f.due   = due;
      f.stale = 1'b0;
      inflight.push_back(f);
      m_fetch_pc = m_fetch_pc + 32'd4;
    end
  endtask

  task automatic run(input int n, input int pr, input int pi, input int pd,
                     input int lmin, input int lmax);
    p_ready = pr;
    p_inst  = pi;
    p_redir = pd;
    lat_min = lmin;
    lat_max = lmax;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic idle_inputs();
    redirect_valid = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    inst_ready     = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    cyc      = 0;
    model_reset();

    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check_eq("rst_inst_valid", 32'(inst_valid), 32'd0);
    check_eq("rst_inst_data", inst_data, 32'd0);
    check_eq("rst_inst_pc", inst_pc, 32'd0);
    check_eq("rst_req_addr", imem_req_addr, RESET_PC);
    @(negedge clk);
    reset_n = 1'b1;

    // Back-to-back streaming with a one-cycle memory.
    run(40, 100, 100, 0, 1, 1);
    // Decode stalled: queue fills and requests stop, then drains.
    run(30, 100, 0, 0, 1, 1);
    run(20, 100, 100, 0, 1, 1);
    // Randomized traffic with redirects and variable latency.
    run(1500, 70, 70, 5, 1, 4);
    run(500, 100, 60, 10, 3, 3);
    run(300, 50, 90, 3, 1, 6);

    // Fill the queue, then assert reset mid-stream.
    run(30, 100, 0, 0, 1, 2);
    check_eq("full_inst_valid", 32'(inst_valid), 32'd1);
    @(negedge clk);
    idle_inputs();
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("midrst_inst_valid", 32'(inst_valid), 32'd0);
    check_eq("midrst_req_valid", 32'(imem_req_valid), 32'd0);
    check_eq("midrst_inst_pc", inst_pc, 32'd0);
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
    check_eq("post_rst_addr", imem_req_addr, RESET_PC);
    run(300, 70, 70, 5, 1, 4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
